// File: rtl/rv32_pkg.sv
// Shared RV32I issue-stage types and constants.
// Opcode values, ALU op encoding and the EX-stage bundle.
package rv32_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_t         op;
  } ex_stage_t;

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake, ALU bus and writeback signals
// of the ALU issue stage.
interface alu_issue_if;

  logic        i_instr_valid;
  logic        o_instr_ready;
  logic [31:0] i_instr;
  logic        i_stall;
  logic [31:0] o_operand_A;
  logic [3:0]  o_operation;
  logic [31:0] o_operand_B;
  logic [31:0] i_result;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_illegal;

  modport master (
    output i_instr_valid, i_instr, i_stall, i_result,
    input  o_instr_ready, o_operand_A, o_operation,
    input  o_operand_B, o_wb_valid, o_wb_rd,
    input  o_wb_data, o_illegal
  );

  modport slave (
    input  i_instr_valid, i_instr, i_stall, i_result,
    output o_instr_ready, o_operand_A, o_operation,
    output o_operand_B, o_wb_valid, o_wb_rd,
    output o_wb_data, o_illegal
  );

endinterface

// File: rtl/reg_file.sv
// Architectural register file: 2 async reads, 1 sync write.
// x0 reads as zero and is never written.
module reg_file #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem [NUM_REGS];

  // Clear all registers on reset; write port ignores x0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage around the external RV32I ALU.
// Decodes OP/OP-IMM, forwards EX->ID, commits one cycle later.
module alu_issue
  import rv32_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst_n,
  alu_issue_if.slave bus
);

  logic [31:0] instr;
  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  assign instr = bus.i_instr;
  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign f7    = instr[31:25];

  logic is_op;
  logic is_imm;
  logic is_shift;
  logic legal;
  logic xfer;
  logic cmt;

  assign is_op    = (opc == OPC_OP);
  assign is_imm   = (opc == OPC_OP_IMM);
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign xfer     = bus.i_instr_valid && !bus.i_stall;

  ex_stage_t ex;
  ex_stage_t dec;

  logic [31:0] rf1;
  logic [31:0] rf2;
  logic [31:0] a_val;
  logic [31:0] b_val;
  logic [31:0] imm;
  logic [31:0] b_raw;

  assign cmt = ex.valid && !bus.i_stall;

  reg_file #(
    .XLEN(XLEN),
    .NUM_REGS(NUM_REGS)
  ) u_rf (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .ra1  (rs1),
    .ra2  (rs2),
    .rd1  (rf1),
    .rd2  (rf2),
    .we   (cmt),
    .wa   (ex.rd),
    .wd   (bus.i_result)
  );

  // Legality of the incoming encoding.
  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      is_op: begin
        legal = (f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) &&
                 (f3 == 3'b000 || f3 == 3'b101));
      end
      is_imm: begin
        if (f3 == 3'b001)
          legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101)
          legal = (f7 == 7'b0000000) ||
                  (f7 == 7'b0100000);
        else
          legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // The in-flight EX result shadows the regfile.
  assign a_val =
    (rs1 == 5'd0) ? 32'd0 :
    (ex.valid && ex.rd != 5'd0 && ex.rd == rs1) ?
      bus.i_result : rf1;

  assign b_val =
    (rs2 == 5'd0) ? 32'd0 :
    (ex.valid && ex.rd != 5'd0 && ex.rd == rs2) ?
      bus.i_result : rf2;

  assign imm   = {{20{instr[31]}}, instr[31:20]};
  assign b_raw = is_op ? b_val : imm;

  // Build the EX bundle; shift amounts are masked to 5 bits.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.rd    = rd;
    dec.a     = a_val;
    dec.b     = is_shift ? {27'd0, b_raw[4:0]} : b_raw;
    dec.op    = alu_op_t'({
                  is_op ? instr[30]
                        : ((f3 == 3'b101) && instr[30]),
                  f3});
  end

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  // EX load/hold/bubble, writeback report and illegal pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex       <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      illegal  <= 1'b0;
    end else begin
      if (!bus.i_stall) begin
        if (xfer && legal)
          ex <= dec;
        else
          ex <= '0;
      end
      illegal  <= xfer && !legal;
      wb_valid <= cmt;
      if (cmt) begin
        wb_rd   <= ex.rd;
        wb_data <= bus.i_result;
      end
    end
  end

  assign bus.o_instr_ready = !bus.i_stall;
  assign bus.o_operand_A   = ex.a;
  assign bus.o_operand_B   = ex.b;
  assign bus.o_operation   = ex.op;
  assign bus.o_wb_valid    = wb_valid;
  assign bus.o_wb_rd       = wb_rd;
  assign bus.o_wb_data     = wb_data;
  assign bus.o_illegal     = illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with an architectural model
// and an ALU stand-in driving i_result.
module tb_alu_issue;

  logic clk;
  logic rst_n;

  alu_issue_if bus ();

  alu_issue dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int ill_exp;
  int ill_seen;

  logic [31:0] arch [32];
  logic [4:0]  q_rd [$];
  logic [31:0] q_dat [$];

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;

  function automatic logic [31:0] alu(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b;
      4'b0010: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'b0011: return (a < b) ? 1 : 0;
      4'b0100: return a ^ b;
      4'b0101: return a >> b;
      4'b1101: return $signed(a) >>> b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  assign bus.i_result = alu(bus.o_operation,
                            bus.o_operand_A,
                            bus.o_operand_B);

  function automatic logic [31:0] rt(
    input logic [6:0] f7, input logic [4:0] s2,
    input logic [4:0] s1, input logic [2:0] f3,
    input logic [4:0] d);
    return {f7, s2, s1, f3, d, OP};
  endfunction

  function automatic logic [31:0] it(
    input logic [11:0] im, input logic [4:0] s1,
    input logic [2:0] f3, input logic [4:0] d);
    return {im, s1, f3, d, OPI};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) arch[i] = '0;
    q_rd.delete();
    q_dat.delete();
  endfunction

  function automatic void model_issue(input logic [31:0] ins);
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [4:0] sh;
    bit ok;
    bit isop;
    opc  = ins[6:0];
    f7   = ins[31:25];
    f3   = ins[14:12];
    d    = ins[11:7];
    isop = (opc == OP);
    ok   = 0;
    if (isop)
      ok = (f7 == 0) ||
           (f7 == 7'h20 && (f3 == 0 || f3 == 5));
    else if (opc == OPI) begin
      if (f3 == 1) ok = (f7 == 0);
      else if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
      else ok = 1;
    end
    if (!ok) begin
      ill_exp++;
      return;
    end
    a  = arch[ins[19:15]];
    b  = isop ? arch[ins[24:20]]
              : {{20{ins[31]}}, ins[31:20]};
    sh = b[4:0];
    case (f3)
      3'd0: r = (isop && ins[30]) ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = ($signed(a) < $signed(b)) ? 1 : 0;
      3'd3: r = (a < b) ? 1 : 0;
      3'd4: r = a ^ b;
      3'd5: r = ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    if (d != 0) arch[d] = r;
    q_rd.push_back(d);
    q_dat.push_back(r);
  endfunction

  logic [4:0]  e_rd;
  logic [31:0] e_dat;

  // Every committed result must match the model, in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_illegal) ill_seen++;
      if (bus.o_wb_valid) begin
        if (q_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wb_extra: got rd=%0d data=%h want none",
                   bus.o_wb_rd, bus.o_wb_data);
        end else begin
          e_rd  = q_rd.pop_front();
          e_dat = q_dat.pop_front();
          chk("wb_rd", 32'(bus.o_wb_rd), 32'(e_rd));
          chk("wb_data", bus.o_wb_data, e_dat);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    bus.i_instr       = ins;
    bus.i_instr_valid = 1'b1;
    model_issue(ins);
    step();
    bus.i_instr_valid = 1'b0;
    bus.i_instr       = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  logic [31:0] tbl [$];

  initial begin
    total    = 0;
    bad      = 0;
    ill_exp  = 0;
    ill_seen = 0;
    rst_n             = 1'b0;
    bus.i_instr_valid = 1'b0;
    bus.i_instr       = '0;
    bus.i_stall       = 1'b0;
    model_reset();
    #12;
    chk("rst_wb_valid", 32'(bus.o_wb_valid), 0);
    chk("rst_wb_rd", 32'(bus.o_wb_rd), 0);
    chk("rst_wb_data", bus.o_wb_data, 0);
    chk("rst_illegal", 32'(bus.o_illegal), 0);
    chk("rst_opA", bus.o_operand_A, 0);
    chk("rst_opB", bus.o_operand_B, 0);
    chk("rst_op", 32'(bus.o_operation), 0);
    chk("rst_ready", 32'(bus.o_instr_ready), 1);
    rst_n = 1'b1;
    step();

    issue(it(12'd5, 5'd0, 3'd0, 5'd1));
    chk("addi_opA", bus.o_operand_A, 0);
    chk("addi_opB", bus.o_operand_B, 5);
    step();
    chk("addi_wb_valid", 32'(bus.o_wb_valid), 1);
    chk("addi_wb_rd", 32'(bus.o_wb_rd), 1);
    chk("addi_wb_data", bus.o_wb_data, 5);

    issue(it(12'hFFF, 5'd0, 3'd0, 5'd1));
    issue(it(12'h004, 5'd1, 3'd5, 5'd2));
    chk("fwd_x1_data", bus.o_wb_data, 32'hFFFFFFFF);
    step();
    chk("fwd_x2_valid", 32'(bus.o_wb_valid), 1);
    chk("fwd_x2_rd", 32'(bus.o_wb_rd), 2);
    chk("fwd_x2_data", bus.o_wb_data, 32'h0FFFFFFF);

    issue(it(12'd7, 5'd0, 3'd0, 5'd1));
    issue(it(12'd9, 5'd0, 3'd0, 5'd2));
    issue(rt(7'h20, 5'd2, 5'd1, 3'd0, 5'd3));
    step();
    chk("sub_rd", 32'(bus.o_wb_rd), 3);
    chk("sub_data", bus.o_wb_data, 32'hFFFFFFFE);

    issue(it(12'd3, 5'd0, 3'd0, 5'd1));
    issue(it(12'h021, 5'd0, 3'd0, 5'd2));
    issue(rt(7'h00, 5'd2, 5'd1, 3'd1, 5'd4));
    chk("sll_opA", bus.o_operand_A, 3);
    chk("sll_opB_masked", bus.o_operand_B, 1);
    step();
    chk("sll_data", bus.o_wb_data, 6);

    issue(32'h00002283);
    chk("ld_illegal", 32'(bus.o_illegal), 1);
    chk("ld_wb_valid", 32'(bus.o_wb_valid), 0);
    step();
    chk("ld_illegal_end", 32'(bus.o_illegal), 0);
    chk("ld_no_wb", 32'(bus.o_wb_valid), 0);
    issue(rt(7'h01, 5'd2, 5'd1, 3'd0, 5'd5));
    chk("mul_illegal", 32'(bus.o_illegal), 1);
    chk("mul_wb_valid", 32'(bus.o_wb_valid), 0);
    step();
    chk("mul_illegal_end", 32'(bus.o_illegal), 0);
    issue(rt(7'h00, 5'd0, 5'd5, 3'd0, 5'd6));
    step();
    chk("x5_unchanged", bus.o_wb_data, 0);

    issue(it(12'd11, 5'd0, 3'd0, 5'd7));
    bus.i_stall       = 1'b1;
    bus.i_instr       = it(12'd1, 5'd0, 3'd0, 5'd8);
    bus.i_instr_valid = 1'b1;
    #1;
    chk("stall_ready", 32'(bus.o_instr_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_no_wb", 32'(bus.o_wb_valid), 0);
      chk("stall_opB", bus.o_operand_B, 11);
      chk("stall_op", 32'(bus.o_operation), 0);
    end
    bus.i_stall = 1'b0;
    issue(it(12'd1, 5'd0, 3'd0, 5'd8));
    chk("rel_wb_valid", 32'(bus.o_wb_valid), 1);
    chk("rel_wb_rd", 32'(bus.o_wb_rd), 7);
    chk("rel_wb_data", bus.o_wb_data, 11);
    step();
    chk("rel_next_rd", 32'(bus.o_wb_rd), 8);

    issue(it(12'd9, 5'd0, 3'd0, 5'd0));
    issue(rt(7'h00, 5'd0, 5'd0, 3'd0, 5'd9));
    chk("x0_wb_valid", 32'(bus.o_wb_valid), 1);
    chk("x0_wb_rd", 32'(bus.o_wb_rd), 0);
    chk("x0_wb_data", bus.o_wb_data, 9);
    step();
    chk("x0_read_zero", bus.o_wb_data, 0);

    tbl = '{
      it(12'hFF8, 5'd0, 3'd0, 5'd11),
      it(12'd3, 5'd0, 3'd0, 5'd12),
      rt(7'h20, 5'd12, 5'd11, 3'd5, 5'd13),
      rt(7'h00, 5'd12, 5'd11, 3'd5, 5'd14),
      rt(7'h00, 5'd12, 5'd11, 3'd2, 5'd15),
      rt(7'h00, 5'd12, 5'd11, 3'd3, 5'd16),
      rt(7'h00, 5'd12, 5'd11, 3'd4, 5'd17),
      rt(7'h00, 5'd12, 5'd11, 3'd6, 5'd18),
      rt(7'h00, 5'd12, 5'd11, 3'd7, 5'd19),
      it(12'h401, 5'd11, 3'd5, 5'd20),
      it(12'hFFF, 5'd12, 3'd3, 5'd21),
      it(12'hFFF, 5'd11, 3'd4, 5'd22),
      it(12'h0F0, 5'd11, 3'd7, 5'd23),
      it(12'h01F, 5'd12, 3'd1, 5'd24),
      it(12'h401, 5'd12, 3'd1, 5'd25),
      it(12'hFFE, 5'd11, 3'd2, 5'd26),
      rt(7'h00, 5'd24, 5'd13, 3'd0, 5'd27)
    };
    foreach (tbl[i]) issue(tbl[i]);
    step();
    step();

    issue(it(12'd7, 5'd0, 3'd0, 5'd5));
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wb", 32'(bus.o_wb_valid), 0);
    chk("mid_rst_opB", bus.o_operand_B, 0);
    model_reset();
    #1;
    rst_n = 1'b1;
    step();
    chk("mid_rst_no_commit", 32'(bus.o_wb_valid), 0);
    issue(rt(7'h00, 5'd5, 5'd1, 3'd0, 5'd10));
    step();
    chk("post_rst_data", bus.o_wb_data, 0);
    step();
    step();

    chk("queue_drained", q_rd.size(), 0);
    chk("illegal_count", ill_seen, ill_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
